// File: rtl/pulse_sync_tx.sv
// pulse_sync_tx: source half of a single-bit event crossing; queues event pulses
// in a saturating counter and launches each over a 4-phase req/ack handshake.
module pulse_sync_tx #(
   parameter int CNT_W       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             data,
   input  logic             ack_in,
   output logic             req_out,
   output logic [CNT_W-1:0] pending,
   output logic             busy,
   output logic             sent,
   output logic             overflow
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] ACK_LOW = 2'd2;
   logic [1:0]             r_state;
   logic [1:0]             w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_pending;
   logic                   r_req;
   logic                   r_busy;
   logic                   r_sent;
   logic                   r_ovf;
   logic                   w_ack_s;
   logic                   w_dec;
   logic                   w_inc_only;
   logic                   w_full;
   assign w_ack_s    = r_sync[SYNC_STAGES-1];
   assign w_full     = &r_pending;
   // IDLE also waits for ack_s low so a stale ack left over from a reset cannot
   // be mistaken for the answer to a fresh request.
   assign w_next     = (r_state == IDLE) ? ((r_pending != '0 && !w_ack_s) ? REQ : IDLE) :
                       (r_state == REQ)  ? (w_ack_s ? ACK_LOW : REQ) :
                                           (w_ack_s ? ACK_LOW : IDLE);
   assign w_dec      = (r_state == IDLE) && (w_next == REQ);
   assign w_inc_only = data && !w_dec;
   always_ff @(posedge clk1) begin
      if (rst) begin
         r_sync    <= '0;
         r_state   <= IDLE;
         r_pending <= '0;
         r_req     <= 1'b0;
         r_busy    <= 1'b0;
         r_sent    <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], ack_in};
         r_state   <= w_next;
         r_req     <= (w_next == REQ);
         r_busy    <= (w_next != IDLE);
         r_sent    <= (r_state == REQ) && w_ack_s;
         r_pending <= (w_inc_only && !w_full) ? r_pending + CNT_W'(1) :
                      (w_dec && !data)        ? r_pending - CNT_W'(1) : r_pending;
         r_ovf     <= r_ovf | (w_inc_only && w_full);
      end
   end
   assign req_out  = r_req;
   assign pending  = r_pending;
   assign busy     = r_busy;
   assign sent     = r_sent;
   assign overflow = r_ovf;
endmodule

// File: tb/tb_pulse_sync_tx.sv
// tb_pulse_sync_tx: directed and randomized checks of pulse_sync_tx against a
// cycle-level behavioural model of the event queue and handshake.
module tb_pulse_sync_tx;
   localparam int CW   = 2;
   localparam int SS   = 2;
   localparam int MAXC = (1 << CW) - 1;
   logic          clk1 = 1'b0;
   logic          clk2 = 1'b0;
   logic          rst  = 1'b1;
   logic          data = 1'b0;
   logic          ack_in;
   logic          ack_man = 1'b0;
   logic          ack2 = 1'b0;
   logic [2:0]    lb = '0;
   int            mode = 0;
   logic          req_out;
   logic [CW-1:0] pending;
   logic          busy;
   logic          sent;
   logic          overflow;
   int            n_vec = 0;
   int            n_bad = 0;
   int            m_cnt = 0;
   int            m_ph = 0;
   logic          m_ovf = 1'b0;
   logic          m_sent = 1'b0;
   logic [SS-1:0] m_sync = '0;
   int            n_sent = 0;
   int            peak = 0;
   pulse_sync_tx #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (
      .clk1(clk1), .rst(rst), .data(data), .ack_in(ack_in), .req_out(req_out),
      .pending(pending), .busy(busy), .sent(sent), .overflow(overflow)
   );
   initial forever #10 clk1 = ~clk1;
   initial begin
      #5;
      forever #20 clk2 = ~clk2;
   end
   // mode 0: manual ack, 1: req_out echoed 3 clk1 later, 2: echoed by a 40 ns clock
   always @(negedge clk1) lb <= {lb[1:0], req_out};
   always @(posedge clk2) ack2 <= req_out;
   assign ack_in = (mode == 0) ? ack_man : (mode == 1) ? lb[2] : ack2;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      logic a_s;
      logic launch;
      int   nph;
      @(posedge clk1);
      if (rst) begin
         m_cnt = 0; m_ph = 0; m_ovf = 1'b0; m_sent = 1'b0; m_sync = '0;
      end else begin
         a_s    = m_sync[SS-1];
         launch = (m_ph == 0) && (m_cnt != 0) && !a_s;
         m_sent = (m_ph == 1) && a_s;
         nph    = launch ? 1 : (m_ph == 1 && a_s) ? 2 : (m_ph == 2 && !a_s) ? 0 : m_ph;
         if (data && !launch) begin
            if (m_cnt == MAXC) m_ovf = 1'b1;
            else m_cnt++;
         end else if (launch && !data) m_cnt--;
         m_ph   = nph;
         m_sync = {m_sync[SS-2:0], ack_in};
      end
      #1;
      chk("model_req", req_out, m_ph == 1);
      chk("model_pending", pending, m_cnt);
      chk("model_busy", busy, m_ph != 0);
      chk("model_sent", sent, m_sent);
      chk("model_overflow", overflow, m_ovf);
      n_sent += sent;
      if (pending > peak) peak = pending;
   endtask
   task automatic do_reset();
      mode = 0; ack_man = 1'b0; data = 1'b0; rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      cyc(); cyc();
   endtask
   initial begin
      #1;
      do_reset();
      chk("reset_req", req_out, 0);
      chk("reset_pending", pending, 0);
      chk("reset_busy", busy, 0);
      chk("reset_overflow", overflow, 0);
      // single event with 3-cycle loopback
      mode = 1; n_sent = 0;
      data = 1'b1; cyc(); data = 1'b0;
      chk("single_pending1", pending, 1);
      chk("single_req_early", req_out, 0);
      cyc();
      chk("single_req_2cyc", req_out, 1);
      chk("single_pending0", pending, 0);
      for (int i = 0; i < 20; i++) cyc();
      chk("single_sent", n_sent, 1);
      chk("single_end_pending", pending, 0);
      chk("single_end_busy", busy, 0);
      // burst of three
      n_sent = 0; peak = 0;
      for (int i = 0; i < 3; i++) begin
         data = 1'b1; cyc();
      end
      data = 1'b0;
      for (int i = 0; i < 60; i++) cyc();
      chk("burst_peak", peak, 2);
      chk("burst_sent", n_sent, 3);
      chk("burst_pending", pending, 0);
      chk("burst_overflow", overflow, 0);
      // saturation with ack held low
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         data = 1'b1; cyc(); data = 1'b0; cyc();
         if (i == 1) chk("sat_launch", req_out, 1);
         if (i == 4) chk("sat_full", pending, 3);
         if (i == 4) chk("sat_no_ovf", overflow, 0);
      end
      chk("sat_ovf", overflow, 1);
      chk("sat_hold", pending, 3);
      // simultaneous increment and launch while full
      do_reset();
      for (int i = 0; i < 4; i++) begin
         data = 1'b1; cyc(); data = 1'b0; cyc();
      end
      chk("sim_full", pending, 3);
      ack_man = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      chk("sim_acklow_req", req_out, 0);
      ack_man = 1'b0;
      for (int i = 0; i < 10 && busy; i++) cyc();
      chk("sim_idle", busy, 0);
      data = 1'b1; cyc(); data = 1'b0;
      chk("sim_pending", pending, 3);
      chk("sim_ovf", overflow, 0);
      chk("sim_req", req_out, 1);
      // reset while in REQ with ack high
      ack_man = 1'b1; cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("rreq_req", req_out, 0);
      chk("rreq_pending", pending, 0);
      chk("rreq_busy", busy, 0);
      chk("rreq_sent", sent, 0);
      chk("rreq_ovf", overflow, 0);
      cyc(); cyc(); cyc();
      data = 1'b1; cyc(); data = 1'b0;
      chk("rreq_evt", pending, 1);
      for (int i = 0; i < 4; i++) cyc();
      chk("rreq_stale", req_out, 0);
      ack_man = 1'b0;
      cyc(); cyc();
      chk("rreq_wait", req_out, 0);
      cyc();
      chk("rreq_rise", req_out, 1);
      ack_man = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      ack_man = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      // slow destination clock echo
      do_reset();
      mode = 2; n_sent = 0;
      for (int i = 0; i < 8; i++) begin
         data = 1'b1; cyc(); data = 1'b0;
         for (int j = 0; j < 11; j++) cyc();
      end
      for (int i = 0; i < 60; i++) cyc();
      chk("slow_sent", n_sent, 8);
      chk("slow_ovf", overflow, 0);
      chk("slow_pending", pending, 0);
      // randomized traffic with loopback and occasional reset
      do_reset();
      mode = 1;
      for (int i = 0; i < 400; i++) begin
         data = ($urandom_range(0, 3) == 0);
         rst  = ($urandom_range(0, 99) == 0);
         cyc();
      end
      rst = 1'b0; data = 1'b0;
      for (int i = 0; i < 60; i++) cyc();
      chk("rand_drain_busy", busy, 0);
      chk("rand_drain_pending", pending, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pulse_sync_tx.md
# pulse_sync_tx

Source-side half of a single-bit event crossing: runs in the fast clock domain, counts single-cycle event pulses on `data`, and delivers each one to a slower destination domain over a 4-phase req/ack level handshake. Events arriving faster than the handshake completes are queued in a saturating counter, so bursts are not lost. The destination-side receiver synchronizes `req_out` and returns `ack_in`. This block synchronizes `ack_in` internally.

## Interface
- `CNT_W`, 4: width of the pending-event counter; capacity 2^CNT_W−1 queued events.
- `SYNC_STAGES`, 2: flop stages on `ack_in` (minimum 2).

- `clk1`  in  1  fast clock (50 MHz nominal); all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data`  in  1  event input; every `clk1` cycle sampled high is one event.
- `ack_in`  in  1  asynchronous level ack from destination domain.
- `req_out`  out  1  registered level request to destination domain.
- `pending`  out  CNT_W  events accepted but not yet launched.
- `busy`  out  1  high whenever FSM is not IDLE.
- `sent`  out  1  one-cycle pulse when destination acknowledges an event.
- `overflow`  out  1  sticky; set when an event is dropped at saturation.

## Operation
- Reset (`rst`=1 at an edge): FSM→IDLE; `req_out`=0, `pending`=0, `busy`=0, `sent`=0, `overflow`=0, synchronizer flops=0.
- `ack_s` = output of last synchronizer stage.
- Counter, per edge: inc = `data`; dec = FSM takes IDLE→REQ.
  - inc & !dec: `pending`+1; at all-ones, hold and set `overflow`.
  - dec & !inc: `pending`−1.
  - inc & dec: unchanged (no overflow even when full).
- FSM states:
  - IDLE: `req_out`=0. Go to REQ when `pending`≠0 and `ack_s`=0. The `ack_s`=0 check guards a stale ack after reset.
  - REQ: `req_out`=1. Go to ACK_LOW when `ack_s`=1; pulse `sent` on that edge.
  - ACK_LOW: `req_out`=0. Go to IDLE when `ack_s`=0.
- `req_out` is a direct flop output, decoded from next-state. It must not be driven from combinational logic.
- `overflow` is cleared only by `rst`.
- Reset mid-handshake: `req_out` drops on the reset edge. Queued events are discarded. No new `req_out` until `ack_s` has been seen low.

## Timing
- `data` high at edge t: `pending` updates after t. If IDLE and `ack_s`=0, `req_out`=1 after edge t+1, so latency is 2 `clk1` cycles.
- `ack_in` rise to `req_out` fall: SYNC_STAGES+1 edges. `ack_in` fall to IDLE: SYNC_STAGES+1 edges.
- Back-to-back events: the next `req_out` rise occurs one edge after IDLE is entered.
- `sent` is high for exactly one cycle per handshake, coincident with the first `req_out`=0 cycle of ACK_LOW.
- `busy` = (state≠IDLE), registered with the state.
- Destination must hold `ack_in` stable per 4-phase rules. No glitch filtering beyond synchronization.

## Test plan
- Single event; `ack_in` loopback of `req_out` delayed 3 `clk1`: `data` 1 cycle → `pending` 1 for 1 cycle, `req_out` high 2 cycles after `data`; then one `sent` pulse, final `pending`=0, `busy`=0.
- Burst: `data` high 3 consecutive cycles with loopback ack → `pending` peaks at 2; 3 complete handshakes; 3 `sent` pulses; end `pending`=0, `overflow`=0.
- Saturation, CNT_W=2, `ack_in` held 0: 5 single-cycle events → first event launches (`req_out`=1), `pending`=3 after event 4, `overflow`=1 after event 5, `pending` stays 3.
- Simultaneous inc/dec: `pending`=3 (CNT_W=2, full), FSM reaches IDLE in the same cycle `data`=1 → `pending` stays 3, `overflow` stays 0, `req_out` rises.
- Reset in REQ with `ack_in`=1: `rst` 1 cycle → all outputs 0. New event with `ack_in` still 1 → `pending`=1, `req_out` stays 0. Drop `ack_in` → `req_out` rises SYNC_STAGES+1 edges later.
- Reference clocks: 20 ns `clk1` with destination echoing from a 40 ns clock. Send 8 events spaced ≥130 ns → exactly 8 `sent` pulses, `overflow`=0.
